// File: rtl/arb_mux_rr_pkg.sv
// Shared definitions for the arbitrated N:1 output mux: mode encodings and
// an elaboration-time ceil(log2) helper.
package arb_mux_rr_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int unsigned MIN_CHANNELS = 2;
    localparam int unsigned MAX_CHANNELS = 16;

    // Smallest r with 2**r >= v; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin search from ptr, or fixed
// priority where the lowest index wins.
module rr_arbiter
    import arb_mux_rr_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = 0;
        any        = |req;

        if (mode == MODE_FIXED) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    found         = 1'b1;
                    gnt_idx       = SEL_W'(i);
                    gnt_onehot[i] = 1'b1;
                end
            end
        end else begin
            // Search upward from ptr, wrapping N-1 -> 0.
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && req[idx]) begin
                    found           = 1'b1;
                    gnt_idx         = SEL_W'(idx);
                    gnt_onehot[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux_rr.sv
// N-channel arbitrated mux with valid/ready handshakes into a single
// registered output stage; round-robin or fixed-priority selection.
module arb_mux_rr
    import arb_mux_rr_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    if (N < MIN_CHANNELS || N > MAX_CHANNELS) begin : gen_bad_n
        $error("arb_mux_rr: N must lie in 2..16");
    end
    if (SEL_W != clog2(N)) begin : gen_bad_sel_w
        $error("arb_mux_rr: SEL_W must equal ceil(log2(N))");
    end

    logic [N-1:0]     gnt_onehot;
    logic [SEL_W-1:0] gnt_idx;
    logic             any_req;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req        (in_valid),
        .ptr        (rr_ptr_q),
        .mode       (mode),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    // Reset suppresses the handshake so no producer believes its word was taken.
    assign load     = (!out_valid_q || out_ready) && any_req && !rst;
    assign in_ready = gnt_onehot & {N{load}};

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_onehot[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = gnt_idx;
            // Advances in fixed mode too, so a return to round-robin stays fair.
            rr_ptr_d    = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
